// File: rtl/layeriomem_pkg.sv
// Shared definitions for the ping-pong layer-I/O buffer.
//   LAYERIOMEM_NBANKS / LAYERIOMEM_DEPTH : default geometry
//   LayeriomemRow / LayeriomemWordAddr   : row and word-address types for that geometry
//   wr_state_t / rd_state_t              : write and read FSM encodings
//   ceil_div                             : integer ceiling division (word count -> beats)
package layeriomem_pkg;

    localparam int LAYERIOMEM_NBANKS = 4;
    localparam int LAYERIOMEM_DEPTH  = 8192;

    typedef logic [$clog2(LAYERIOMEM_DEPTH/LAYERIOMEM_NBANKS)-1:0] LayeriomemRow;
    typedef logic [$clog2(LAYERIOMEM_DEPTH/2):0]                   LayeriomemWordAddr;

    typedef enum logic {WR_IDLE, WR_RUN} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/layeriomem_pingpong_banked_bank.sv
// One bank of the layer-I/O buffer: simple dual-port RAM, ROWS x W.
// The synchronous RAM read forms the first stage; the remaining RDLATENCY-1 stages
// carry the word to the output register, so rdata lags a read by RDLATENCY cycles.
// Ports:
//   clk              clock
//   we/waddr/wdata   write port
//   re/raddr         read port (row captured when re is high)
//   rdata            read data, RDLATENCY cycles after re
// RAM content has no reset.
module layeriomem_bank #(
    parameter int W         = 128,
    parameter int ROWS      = 2048,
    parameter int RW        = 11,
    parameter int RDLATENCY = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [RW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem  [ROWS];
    logic [W-1:0] pipe [RDLATENCY];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) pipe[0] <= mem[raddr];
        for (int i = 1; i < RDLATENCY; i++) pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[RDLATENCY-1];

endmodule

// File: rtl/layeriomem_pingpong_banked.sv
// Ping-pong layer-I/O buffer. One word is written per beat, striped round-robin across
// NBANKS banks; each read beat gathers one row from every bank (NBANKS words). Two
// regions alternate: the writer fills region wsel while the reader drains region rsel.
// Ports:
//   clk, resetn (async, active-low), soft_resetn (sync, active-low, RAM kept)
//   start, wr_size, islastlayer           layer configuration (taken in write IDLE)
//   wr_valid/wr_ready/wr_data             write handshake: transfer when both high
//   rd_req/rd_ready                       read-beat handshake: accept when both high
//   q_valid/q_data/q_lanes/q_last         read data, RDLATENCY cycles after accept
//   wrote_layer, wrote_inference          one-cycle completion pulses
// Optional feature: macro LAYERIOMEM_PERF_EN adds saturating 32-bit stall counters
// wr_stall_cycles (wr_valid && !wr_ready) and rd_stall_cycles (rd_req && !rd_ready).
import layeriomem_pkg::*;

module layeriomem_pingpong_banked #(
    parameter int A_WIDTH   = 8,
    parameter int SZJ       = 16,
    parameter int NBANKS    = LAYERIOMEM_NBANKS,
    parameter int DEPTH     = LAYERIOMEM_DEPTH,
    parameter int RDLATENCY = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          soft_resetn,
    input  logic                          start,
    input  logic [$clog2(DEPTH/2):0]      wr_size,
    input  logic                          islastlayer,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [SZJ*A_WIDTH-1:0]        wr_data,
    input  logic                          rd_req,
    output logic                          rd_ready,
    output logic                          q_valid,
    output logic [NBANKS*SZJ*A_WIDTH-1:0] q_data,
    output logic [NBANKS-1:0]             q_lanes,
    output logic                          q_last,
    output logic                          wrote_layer,
    output logic                          wrote_inference
`ifdef LAYERIOMEM_PERF_EN
    ,
    output logic [31:0]                   wr_stall_cycles,
    output logic [31:0]                   rd_stall_cycles
`endif
);

    localparam int W         = SZJ*A_WIDTH;
    localparam int CW        = $clog2(DEPTH/2) + 1;
    localparam int ROWS      = DEPTH/NBANKS;
    localparam int HALF_ROWS = DEPTH/(2*NBANKS);
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic          wsel, rsel;
    logic [1:0]    region_full;
    logic [CW-1:0] region_size [2];
    logic [CW-1:0] wr_addr, wr_len, rd_beat, rd_beats;
    logic          wr_last_layer;
    logic          wr_fire, wr_done, rd_fire, rd_done, wr_take;
    logic [RW-1:0] wr_row, rd_row;
    logic [NBANKS-1:0] bank_we, issue_lanes;
    logic [W-1:0]      bank_rdata [NBANKS];

    logic [RDLATENCY-1:0] vld_pipe, last_pipe;
    logic [NBANKS-1:0]    lanes_pipe [RDLATENCY];

    assign wr_ready = (wr_state == WR_RUN) && !region_full[wsel];
    assign rd_ready = (rd_state == RD_RUN);
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_done  = wr_fire && (wr_addr == wr_len - 1'b1);
    assign rd_fire  = rd_req && rd_ready;
    assign rd_done  = rd_fire && (rd_beat == rd_beats - 1'b1);
    assign wr_take  = (wr_state == WR_IDLE) && start && (wr_size != '0);

    // Region r occupies rows [r*HALF_ROWS, (r+1)*HALF_ROWS) of every bank.
    assign wr_row = RW'((wsel ? HALF_ROWS : 0) + int'(wr_addr) / NBANKS);
    assign rd_row = RW'((rsel ? HALF_ROWS : 0) + int'(rd_beat));

    always_comb begin
        int n;
        wr_state_nxt = wr_state;
        rd_state_nxt = rd_state;
        bank_we      = '0;
        issue_lanes  = '1;
        n            = NBANKS;
        case (wr_state)
            WR_IDLE: if (wr_take) wr_state_nxt = WR_RUN;
            WR_RUN:  if (wr_done) wr_state_nxt = WR_IDLE;
            default: wr_state_nxt = WR_IDLE;
        endcase
        case (rd_state)
            RD_IDLE: if (region_full[rsel]) rd_state_nxt = RD_RUN;
            RD_RUN:  if (rd_done) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
        for (int k = 0; k < NBANKS; k++)
            bank_we[k] = wr_fire && ((int'(wr_addr) % NBANKS) == k);
        // Only the final beat of a region can be partial.
        if (rd_done) begin
            n = int'(region_size[rsel]) % NBANKS;
            if (n == 0) n = NBANKS;
            for (int k = 0; k < NBANKS; k++) issue_lanes[k] = (k < n);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else if (!soft_resetn) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wsel <= 1'b0; rsel <= 1'b0; region_full <= 2'b00;
            region_size[0] <= '0; region_size[1] <= '0;
            wr_addr <= '0; wr_len <= '0; wr_last_layer <= 1'b0;
            rd_beat <= '0; rd_beats <= '0;
            wrote_layer <= 1'b0; wrote_inference <= 1'b0;
        end else if (!soft_resetn) begin
            wsel <= 1'b0; rsel <= 1'b0; region_full <= 2'b00;
            region_size[0] <= '0; region_size[1] <= '0;
            wr_addr <= '0; wr_len <= '0; wr_last_layer <= 1'b0;
            rd_beat <= '0; rd_beats <= '0;
            wrote_layer <= 1'b0; wrote_inference <= 1'b0;
        end else begin
            wrote_layer     <= wr_done;
            wrote_inference <= wr_done && wr_last_layer;
            if (wr_take) begin
                wr_len        <= wr_size;
                wr_last_layer <= islastlayer;
                wr_addr       <= '0;
            end else if (wr_fire) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (wr_done) region_size[wsel] <= wr_len;
            wsel <= wsel ^ wr_done;
            // Set (writer) and clear (reader) always target different regions.
            region_full <= (region_full | {wr_done & wsel, wr_done & ~wsel})
                         & ~{rd_done & rsel, rd_done & ~rsel};
            if (rd_state == RD_IDLE && region_full[rsel]) begin
                rd_beats <= CW'(ceil_div(int'(region_size[rsel]), NBANKS));
                rd_beat  <= '0;
            end else if (rd_fire) begin
                rd_beat <= rd_beat + 1'b1;
            end
            rsel <= rsel ^ rd_done;
        end
    end

    // Control pipeline travels alongside the bank read pipelines.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0; last_pipe <= '0;
            for (int i = 0; i < RDLATENCY; i++) lanes_pipe[i] <= '0;
        end else if (!soft_resetn) begin
            vld_pipe <= '0; last_pipe <= '0;
            for (int i = 0; i < RDLATENCY; i++) lanes_pipe[i] <= '0;
        end else begin
            vld_pipe[0]   <= rd_fire;
            last_pipe[0]  <= rd_done;
            lanes_pipe[0] <= rd_fire ? issue_lanes : '0;
            for (int i = 1; i < RDLATENCY; i++) begin
                vld_pipe[i]   <= vld_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
                lanes_pipe[i] <= lanes_pipe[i-1];
            end
        end
    end

    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        layeriomem_bank #(
            .W(W), .ROWS(ROWS), .RW(RW), .RDLATENCY(RDLATENCY)
        ) u_bank (
            .clk(clk), .we(bank_we[g]), .waddr(wr_row), .wdata(wr_data),
            .re(rd_fire), .raddr(rd_row), .rdata(bank_rdata[g])
        );
    end

    assign q_valid = vld_pipe[RDLATENCY-1];
    assign q_last  = last_pipe[RDLATENCY-1];
    assign q_lanes = lanes_pipe[RDLATENCY-1];

    // Lanes outside the mask (and everything while idle) read as zero.
    always_comb begin
        q_data = '0;
        for (int k = 0; k < NBANKS; k++)
            if (q_lanes[k]) q_data[k*W +: W] = bank_rdata[k];
    end

`ifdef LAYERIOMEM_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_stall_cycles <= '0;
            rd_stall_cycles <= '0;
        end else if (!soft_resetn) begin
            wr_stall_cycles <= '0;
            rd_stall_cycles <= '0;
        end else begin
            if (wr_valid && !wr_ready && wr_stall_cycles != '1)
                wr_stall_cycles <= wr_stall_cycles + 1'b1;
            if (rd_req && !rd_ready && rd_stall_cycles != '1)
                rd_stall_cycles <= rd_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_layeriomem_pingpong_banked.sv
// Directed bench for layeriomem_pingpong_banked with NBANKS=4, DEPTH=64 (32 words
// per region), 32-bit words, RDLATENCY=3.
module tb_layeriomem_pingpong_banked;

    localparam int A_WIDTH = 8;
    localparam int SZJ     = 4;
    localparam int NBANKS  = 4;
    localparam int DEPTH   = 64;
    localparam int RDLAT   = 3;
    localparam int W       = SZJ*A_WIDTH;

    logic clk = 1'b0;
    logic resetn = 1'b0, soft_resetn = 1'b1, start = 1'b0, islastlayer = 1'b0;
    logic [5:0] wr_size = '0;
    logic wr_valid = 1'b0, wr_ready, rd_req = 1'b0, rd_ready;
    logic [W-1:0] wr_data = '0;
    logic q_valid, q_last, wrote_layer, wrote_inference;
    logic [NBANKS*W-1:0] q_data;
    logic [NBANKS-1:0] q_lanes;
`ifdef LAYERIOMEM_PERF_EN
    logic [31:0] wr_stall_cycles, rd_stall_cycles;
`endif

    int n_tests = 0, n_fail = 0, cyc = 0, wl_cnt = 0, wi_cnt = 0, wl_before = 0;
    int acc_q[$];
    logic [NBANKS*W-1:0] exp_q[$];
    logic [NBANKS-1:0]   exp_lanes_q[$];
    logic                exp_last_q[$];

    layeriomem_pingpong_banked #(
        .A_WIDTH(A_WIDTH), .SZJ(SZJ), .NBANKS(NBANKS), .DEPTH(DEPTH), .RDLATENCY(RDLAT)
    ) dut (
        .clk(clk), .resetn(resetn), .soft_resetn(soft_resetn), .start(start),
        .wr_size(wr_size), .islastlayer(islastlayer), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .rd_req(rd_req), .rd_ready(rd_ready),
        .q_valid(q_valid), .q_data(q_data), .q_lanes(q_lanes), .q_last(q_last),
        .wrote_layer(wrote_layer), .wrote_inference(wrote_inference)
`ifdef LAYERIOMEM_PERF_EN
        , .wr_stall_cycles(wr_stall_cycles), .rd_stall_cycles(rd_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word(input int layer, input int i);
        return {8'hA5, 8'(layer), 16'(i)};
    endfunction

    task automatic check(input string tag, input logic [NBANKS*W-1:0] obs,
                         input logic [NBANKS*W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input int layer, input int first,
                               input logic [NBANKS-1:0] lanes, input logic last);
        logic [NBANKS*W-1:0] d;
        d = '0;
        for (int k = 0; k < NBANKS; k++)
            if (lanes[k]) d[k*W +: W] = word(layer, first + k);
        exp_q.push_back(d);
        exp_lanes_q.push_back(lanes);
        exp_last_q.push_back(last);
    endtask

    // One clock: record accepts, then check read data against the expected queue.
    task automatic tick();
        logic due;
        if (rd_req && rd_ready) acc_q.push_back(cyc);
        @(posedge clk);
        if (!soft_resetn) acc_q.delete();
        cyc++;
        #1;
        if (wrote_layer) wl_cnt++;
        if (wrote_inference) wi_cnt++;
        due = (acc_q.size() > 0) && (acc_q[0] + RDLAT == cyc);
        if (q_valid || due) begin
            check("q_valid_timing", q_valid, due);
            if (due) void'(acc_q.pop_front());
            if (q_valid) begin
                if (exp_q.size() == 0) check("q_valid_unexpected", q_valid, 0);
                else begin
                    check("q_data", q_data, exp_q.pop_front());
                    check("q_lanes", q_lanes, exp_lanes_q.pop_front());
                    check("q_last", q_last, exp_last_q.pop_front());
                end
            end
        end
    endtask

    task automatic write_words(input int layer, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            int budget;
            budget = 0;
            wr_valid = 1'b1;
            wr_data  = word(layer, first + i);
            while (!wr_ready && budget < 200) begin tick(); budget++; end
            if (!wr_ready) begin
                check("wr_ready_timeout", wr_ready, 1);
                wr_valid = 1'b0;
                return;
            end
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_beats(input int n);
        int acc, budget;
        acc = 0; budget = 0;
        rd_req = 1'b1;
        while (acc < n && budget < 200) begin
            if (rd_ready) acc++;
            tick();
            budget++;
        end
        rd_req = 1'b0;
        check("rd_accept_count", acc, n);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 50) begin tick(); budget++; end
        check("drain_beats_left", exp_q.size(), 0);
    endtask

    task automatic configure(input int size, input logic last);
        start = 1'b1; wr_size = 6'(size); islastlayer = last;
        tick();
        start = 1'b0; islastlayer = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_q_valid", q_valid, 0);
        check("rst_q_data", q_data, 0);
        check("rst_q_lanes", q_lanes, 0);
        check("rst_q_last", q_last, 0);
        check("rst_wrote_layer", wrote_layer, 0);
        check("rst_wrote_inference", wrote_inference, 0);

        // rd_req held from reset: no reader activity while both regions empty
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_rd_ready", rd_ready, 0);
        end

        // 10-word layer into region 0, streamed out as 3 beats (last one partial)
        expect_beat(1, 0, 4'b1111, 1'b0);
        expect_beat(1, 4, 4'b1111, 1'b0);
        expect_beat(1, 8, 4'b0011, 1'b1);
        configure(10, 1'b0);
        check("run_wr_ready", wr_ready, 1);
        write_words(1, 0, 10);
        check("l1_wrote_layer", wrote_layer, 1);
        check("l1_rd_ready_still_0", rd_ready, 0);
        tick();
        check("l1_wrote_layer_pulse", wrote_layer, 0);
        check("l1_rd_ready", rd_ready, 1);
        drain();
        rd_req = 1'b0;
        check("l1_rd_ready_released", rd_ready, 0);

        // Fill both regions (8 words each), third layer must stall
        configure(8, 1'b0);
        write_words(2, 0, 8);
        check("l2_wrote_layer", wrote_layer, 1);
        configure(8, 1'b0);
        write_words(3, 0, 8);
        check("l3_wrote_layer", wrote_layer, 1);
        configure(4, 1'b0);
        wr_valid = 1'b1;
        wr_data  = word(4, 0);
        for (int i = 0; i < 5; i++) begin
            check("both_full_wr_ready", wr_ready, 0);
            tick();
        end
        expect_beat(2, 0, 4'b1111, 1'b0);
        expect_beat(2, 4, 4'b1111, 1'b1);
        read_beats(2);
        check("resume_wr_ready", wr_ready, 1);
        write_words(4, 0, 4);
        check("l4_wrote_layer", wrote_layer, 1);
        expect_beat(3, 0, 4'b1111, 1'b0);
        expect_beat(3, 4, 4'b1111, 1'b1);
        expect_beat(4, 0, 4'b1111, 1'b1);
        read_beats(3);
        drain();
        check("no_inference_yet", wi_cnt, 0);

        // Last layer, full region: both pulses once, together
        wl_before = wl_cnt;
        configure(32, 1'b1);
        write_words(5, 0, 32);
        check("l5_wrote_layer", wrote_layer, 1);
        check("l5_wrote_inference", wrote_inference, 1);
        check("l5_wrote_layer_count", wl_cnt, wl_before + 1);
        tick();
        check("l5_wrote_layer_low", wrote_layer, 0);
        check("l5_wrote_inference_low", wrote_inference, 0);
        check("l5_inference_count", wi_cnt, 1);

        // Soft reset with two beats in flight: pipeline flushed, regions cleared
        read_beats(2);
        soft_resetn = 1'b0;
        tick();
        soft_resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flushed_q_valid", q_valid, 0);
        end
        check("sr_rd_ready", rd_ready, 0);
        check("sr_wr_ready", wr_ready, 0);

        // start with wr_size==0 ignored; start while RUN ignored
        configure(0, 1'b0);
        check("zero_size_ignored", wr_ready, 0);
        configure(5, 1'b0);
        wl_before = wl_cnt;
        write_words(6, 0, 2);
        start = 1'b1; wr_size = 6'd1;
        tick();
        start = 1'b0;
        check("start_in_run_no_pulse", wl_cnt, wl_before);
        write_words(6, 2, 3);
        check("l6_wrote_layer", wrote_layer, 1);
        check("l6_wrote_layer_count", wl_cnt, wl_before + 1);
        expect_beat(6, 0, 4'b1111, 1'b0);
        expect_beat(6, 4, 4'b0001, 1'b1);
        read_beats(2);
        drain();

`ifdef LAYERIOMEM_PERF_EN
        soft_resetn = 1'b0;
        tick();
        soft_resetn = 1'b1;
        check("perf_wr_clear", wr_stall_cycles, 0);
        check("perf_rd_clear", rd_stall_cycles, 0);
        wr_valid = 1'b1;
        repeat (5) tick();
        wr_valid = 1'b0;
        check("perf_wr_stall", wr_stall_cycles, 5);
        rd_req = 1'b1;
        repeat (3) tick();
        rd_req = 1'b0;
        check("perf_rd_stall", rd_stall_cycles, 3);
`endif

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
